ex_mem_stage: RTL and testbench

EX/MEM pipeline stage sitting directly downstream of the ALU. It registers the ALU result and flags together with the instruction's memory/writeback controls, and resolves conditional branches and jumps from the ALU flags. On a taken branch or jump it issues a one-cycle PC redirect and squashes the wrong-path instructions that follow. Throughput is one instruction per cycle, with valid/ready back-pressure from MEM.

---
 rtl/ex_mem_stage.sv | 120 ++++++++++++
 tb/tb_ex_mem_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: resolves branches/jumps from ALU flags, issues a
// one-cycle PC redirect and squashes the wrong-path instructions behind it.
module ex_mem_stage #(
  parameter int SHADOW = 2,
  localparam int SW = $clog2(SHADOW + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   alu_out,
  input  logic          z,
  input  logic          c,
  input  logic          v,
  input  logic [31:0]   pc,
  input  logic [31:0]   imm,
  input  logic [31:0]   rs2_data,
  input  logic [4:0]    rd,
  input  logic          reg_write,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic          branch,
  input  logic          jump,
  input  logic [2:0]    br_funct3,
  input  logic [2:0]    mem_funct3,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   m_result,
  output logic [31:0]   m_rs2,
  output logic [4:0]    m_rd,
  output logic          m_reg_write,
  output logic          m_mem_read,
  output logic          m_mem_write,
  output logic [2:0]    m_mem_funct3,
  output logic          redirect,
  output logic [31:0]   redirect_pc,
  output logic [31:0]   branch_cnt,
  output logic [31:0]   taken_cnt,
  output logic [SW-1:0] shadow_dbg
);

  // Handshake: EX->stage transfers when in_valid & in_ready; stage->MEM
  // transfers when out_valid & out_ready. out_valid and m_* never change
  // while out_valid & ~out_ready.

  logic [SW-1:0] shadow;
  logic          accept;
  logic          eq, lt, ltu;
  logic          cond;
  logic          taken;
  logic [31:0]   target;

  assign in_ready   = ~out_valid | out_ready;
  assign accept     = in_valid & in_ready & (shadow == '0);
  assign shadow_dbg = shadow;

  assign eq  = z;
  assign lt  = alu_out[31] ^ v;
  assign ltu = ~c;

  always_comb begin
    cond = 1'b0;
    unique case (br_funct3)
      3'b000:  cond = eq;
      3'b001:  cond = ~eq;
      3'b100:  cond = lt;
      3'b101:  cond = ~lt;
      3'b110:  cond = ltu;
      3'b111:  cond = ~ltu;
      default: cond = 1'b0;
    endcase
  end

  assign taken  = jump | (branch & cond);
  assign target = jump ? {alu_out[31:1], 1'b0} : pc + imm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      m_result     <= '0;
      m_rs2        <= '0;
      m_rd         <= '0;
      m_reg_write  <= 1'b0;
      m_mem_read   <= 1'b0;
      m_mem_write  <= 1'b0;
      m_mem_funct3 <= '0;
      redirect     <= 1'b0;
      redirect_pc  <= '0;
      shadow       <= '0;
      branch_cnt   <= '0;
      taken_cnt    <= '0;
    end else begin
      // Pulse regardless of out_ready so the fetch side never misses it.
      redirect <= accept & taken;
      if (accept & taken)
        redirect_pc <= target;
      if (in_ready) begin
        out_valid <= accept;
        if (accept) begin
          m_result     <= jump ? pc + 32'd4 : alu_out;
          m_rs2        <= rs2_data;
          m_rd         <= rd;
          m_reg_write  <= reg_write;
          m_mem_read   <= mem_read;
          m_mem_write  <= mem_write;
          m_mem_funct3 <= mem_funct3;
        end
        if (accept & taken)
          shadow <= SW'(SHADOW);
        else if (shadow != '0)
          shadow <= shadow - SW'(1);
        if (accept & branch)
          branch_cnt <= branch_cnt + 32'd1;
        if (accept & branch & cond)
          taken_cnt <= taken_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus random traffic checked
// against an operand-level reference model (branches decided on a, b).
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] alu_out;
  logic        z, c, v;
  logic [31:0] pc, imm, rs2_data;
  logic [4:0]  rd;
  logic        reg_write, mem_read, mem_write, branch, jump;
  logic [2:0]  br_funct3, mem_funct3;
  logic        out_valid, out_ready;
  logic [31:0] m_result, m_rs2;
  logic [4:0]  m_rd;
  logic        m_reg_write, m_mem_read, m_mem_write;
  logic [2:0]  m_mem_funct3;
  logic        redirect;
  logic [31:0] redirect_pc, branch_cnt, taken_cnt;
  logic [1:0]  shadow_dbg;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.SHADOW(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .z(z), .c(c), .v(v), .pc(pc), .imm(imm),
    .rs2_data(rs2_data), .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .jump(jump), .br_funct3(br_funct3),
    .mem_funct3(mem_funct3), .out_valid(out_valid), .out_ready(out_ready),
    .m_result(m_result), .m_rs2(m_rs2), .m_rd(m_rd), .m_reg_write(m_reg_write),
    .m_mem_read(m_mem_read), .m_mem_write(m_mem_write),
    .m_mem_funct3(m_mem_funct3), .redirect(redirect), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt), .shadow_dbg(shadow_dbg)
  );

  // Reference model state
  logic        e_valid, e_rw, e_mr, e_mw, e_redir;
  logic [31:0] e_result, e_rs2, e_rpc, e_bcnt, e_tcnt;
  logic [4:0]  e_rd;
  logic [2:0]  e_f3;
  int          e_shadow;
  logic [31:0] cur_a, cur_b;

  logic [172:0] act_bus;
  assign act_bus = {out_valid, m_result, m_rs2, m_rd, m_reg_write, m_mem_read,
                    m_mem_write, m_mem_funct3, redirect, redirect_pc,
                    branch_cnt, taken_cnt};

  function automatic logic [172:0] exp_bus();
    return {e_valid, e_result, e_rs2, e_rd, e_rw, e_mr, e_mw, e_f3,
            e_redir, e_rpc, e_bcnt, e_tcnt};
  endfunction

  // Branch decision straight from the operands of the compare.
  function automatic logic ref_cond(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    e_valid = 0; e_result = 0; e_rs2 = 0; e_rd = 0; e_rw = 0; e_mr = 0;
    e_mw = 0; e_f3 = 0; e_redir = 0; e_rpc = 0; e_shadow = 0;
    e_bcnt = 0; e_tcnt = 0;
  endtask

  task automatic model_step();
    logic rdy, cnd, tk;
    rdy = !e_valid || out_ready;
    e_redir = 0;
    if (rdy) begin
      if (in_valid && e_shadow == 0) begin
        cnd = ref_cond(br_funct3, cur_a, cur_b);
        tk  = jump || (branch && cnd);
        e_valid  = 1;
        e_result = jump ? pc + 32'd4 : alu_out;
        e_rs2 = rs2_data; e_rd = rd; e_rw = reg_write; e_mr = mem_read;
        e_mw = mem_write; e_f3 = mem_funct3;
        if (branch) e_bcnt = e_bcnt + 1;
        if (branch && cnd) e_tcnt = e_tcnt + 1;
        if (tk) begin
          e_redir  = 1;
          e_rpc    = jump ? (alu_out & ~32'd1) : pc + imm;
          e_shadow = 2;
        end
      end else begin
        e_valid = 0;
        if (e_shadow > 0) e_shadow = e_shadow - 1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Derive ALU result and flags of a - b.
  task automatic set_op(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    cur_a = a; cur_b = b;
    sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
    alu_out = sum[31:0];
    z = (sum[31:0] == 32'd0);
    c = sum[32];
    v = (a[31] != b[31]) && (sum[31] != a[31]);
  endtask

  task automatic rand_ctrl();
    rs2_data = $urandom; rd = 5'($urandom); mem_funct3 = 3'($urandom);
    reg_write = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
    pc = $urandom; imm = $urandom;
  endtask

  task automatic drive_branch(input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] p,
                              input logic [31:0] im);
    rand_ctrl();
    in_valid = 1; branch = 1; jump = 0; br_funct3 = f;
    reg_write = 0; mem_read = 0; mem_write = 0;
    pc = p; imm = im;
    set_op(a, b);
  endtask

  task automatic drive_jump(input logic [31:0] alu, input logic [31:0] p);
    rand_ctrl();
    in_valid = 1; branch = 0; jump = 1; br_funct3 = 3'($urandom);
    reg_write = 1; mem_read = 0; mem_write = 0; pc = p;
    cur_a = $urandom; cur_b = $urandom;
    alu_out = alu; z = 1'($urandom); c = 1'($urandom); v = 1'($urandom);
  endtask

  task automatic drive_alu(input logic valid);
    rand_ctrl();
    in_valid = valid; branch = 0; jump = 0; br_funct3 = 3'($urandom);
    set_op($urandom, $urandom);
  endtask

  task automatic test_reset();
    rst_n = 0; out_ready = 1;
    drive_alu(0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (act_bus !== 173'd0 || shadow_dbg !== 2'd0) begin
      bad++; $display("FAIL reset outputs act=%h shadow=%0d req=0", act_bus, shadow_dbg);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset in_ready act=%b req=1", in_ready);
    end
    rst_n = 1;
  endtask

  task automatic test_beq_taken();
    drive_branch(3'd0, 32'h55, 32'h55, 32'h100, 32'h20);
    cycle();
    total++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h120 || out_valid !== 1'b1) begin
      bad++; $display("FAIL beq redirect act=%b pc=%h valid=%b req=1 120 1",
                      redirect, redirect_pc, out_valid);
    end
    total++;
    if (branch_cnt !== 32'd1 || taken_cnt !== 32'd1) begin
      bad++; $display("FAIL beq counters act=%0d/%0d req=1/1", branch_cnt, taken_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      drive_alu(1);
      cycle();
      total++;
      if (out_valid !== 1'b0 || redirect !== 1'b0) begin
        bad++; $display("FAIL beq squash%0d act valid=%b redirect=%b req=0 0",
                        i, out_valid, redirect);
      end
    end
    drive_alu(1);
    cycle();
    total++;
    if (out_valid !== 1'b1 || m_result !== e_result) begin
      bad++; $display("FAIL beq after_shadow act valid=%b res=%h req=1 %h",
                      out_valid, m_result, e_result);
    end
  endtask

  task automatic test_blt_not_taken();
    drive_branch(3'd4, 32'h0, 32'h8000_0000, 32'h200, 32'h40);
    cycle();
    total++;
    if (redirect !== 1'b0 || out_valid !== 1'b1 || m_result !== 32'h8000_0000) begin
      bad++; $display("FAIL blt act redirect=%b valid=%b res=%h req=0 1 80000000",
                      redirect, out_valid, m_result);
    end
  endtask

  task automatic test_unsigned();
    drive_branch(3'd7, 32'd1, 32'd2, 32'h300, 32'h10);
    cycle();
    total++;
    if (redirect !== 1'b0) begin
      bad++; $display("FAIL bgeu act redirect=%b req=0", redirect);
    end
    drive_branch(3'd6, 32'd1, 32'd2, 32'h300, 32'h10);
    cycle();
    total++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h310) begin
      bad++; $display("FAIL bltu act redirect=%b pc=%h req=1 310", redirect, redirect_pc);
    end
    drive_alu(0);
    repeat (2) cycle();
  endtask

  task automatic test_jalr();
    logic [31:0] bc;
    bc = e_bcnt;
    drive_jump(32'h0000_2003, 32'h40);
    cycle();
    total++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h2002 || m_result !== 32'h44 ||
        m_reg_write !== 1'b1) begin
      bad++; $display("FAIL jalr act redirect=%b pc=%h res=%h rw=%b req=1 2002 44 1",
                      redirect, redirect_pc, m_result, m_reg_write);
    end
    total++;
    if (branch_cnt !== bc) begin
      bad++; $display("FAIL jalr branch_cnt act=%0d req=%0d", branch_cnt, bc);
    end
    drive_alu(0);
    repeat (2) cycle();
  endtask

  task automatic test_stall();
    drive_branch(3'd1, 32'd7, 32'd9, 32'h500, 32'h80);
    cycle();
    out_ready = 0;
    drive_alu(1);
    rd = 5'd17;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL stall in_ready act=%b req=0", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (act_bus !== exp_bus() || shadow_dbg !== 2'd2 || redirect !== 1'b0) begin
        bad++; $display("FAIL stall hold%0d act=%h sh=%0d req=%h sh=2",
                        i, act_bus, shadow_dbg, exp_bus());
      end
    end
    out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      total++;
      if (out_valid !== 1'b0 || shadow_dbg !== 2'(1 - i)) begin
        bad++; $display("FAIL stall squash%0d act valid=%b sh=%0d req=0 %0d",
                        i, out_valid, shadow_dbg, 1 - i);
      end
    end
    cycle();
    total++;
    if (out_valid !== 1'b1 || m_rd !== 5'd17) begin
      bad++; $display("FAIL stall accept act valid=%b rd=%0d req=1 17", out_valid, m_rd);
    end
  endtask

  task automatic test_reset_mid_shadow();
    drive_branch(3'd0, 32'd3, 32'd3, 32'h600, 32'h8);
    cycle();
    drive_alu(0);
    #2 rst_n = 0;
    #1;
    model_reset();
    total++;
    if (act_bus !== 173'd0 || shadow_dbg !== 2'd0) begin
      bad++; $display("FAIL midreset act=%h sh=%0d req=0", act_bus, shadow_dbg);
    end
    #2 rst_n = 1;
    drive_alu(1);
    cycle();
    total++;
    if (out_valid !== 1'b1 || m_result !== e_result) begin
      bad++; $display("FAIL midreset first act valid=%b res=%h req=1 %h",
                      out_valid, m_result, e_result);
    end
  endtask

  task automatic test_random();
    int kind;
    logic [31:0] a, b;
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 5);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if (kind == 0) drive_alu(0);
      else if (kind <= 2) drive_alu(1);
      else if (kind <= 4) drive_branch(3'($urandom), a, b, $urandom, $urandom);
      else drive_jump($urandom, $urandom);
      #1;
      total++;
      if (in_ready !== (!e_valid || out_ready)) begin
        bad++; $display("FAIL rand%0d in_ready act=%b req=%b", i, in_ready,
                        !e_valid || out_ready);
      end
      cycle();
      total++;
      if (act_bus !== exp_bus() || shadow_dbg !== 2'(e_shadow)) begin
        bad++; $display("FAIL rand%0d outputs act=%h sh=%0d req=%h sh=%0d",
                        i, act_bus, shadow_dbg, exp_bus(), e_shadow);
      end
    end
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_blt_not_taken();
    test_unsigned();
    test_jalr();
    test_stall();
    test_reset_mid_shadow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
